// File: rtl/mmio_reg_bank_pkg.sv
// mmio_pkg: shared types and helpers for the MMIO byte-register bank.
//   mmio_byte_t  - one register byte
//   mmio_mode_e  - per-register behaviour (read/write, read-only, sticky edge capture)
//   mmio_mode()  - derives a register's mode from the RW and sticky masks
//   MMIO_WINDOW  - size of the address window reserved for the bank
package mmio_pkg;

    localparam int MMIO_WINDOW = 256;

    typedef logic [7:0] mmio_byte_t;

    typedef enum logic [1:0] {
        MMIO_RW,
        MMIO_RO,
        MMIO_STICKY
    } mmio_mode_e;

    // The RW bit takes priority: a sticky bit on an RW register has no effect.
    function automatic mmio_mode_e mmio_mode(
        input logic [7:0]             idx,
        input logic [MMIO_WINDOW-1:0] rw_mask,
        input logic [MMIO_WINDOW-1:0] sticky_mask
    );
        if (rw_mask[idx]) begin
            return MMIO_RW;
        end
        if (sticky_mask[idx]) begin
            return MMIO_STICKY;
        end
        return MMIO_RO;
    endfunction

endpackage

// File: rtl/mmio_reg_bank_if.sv
// mmio_reg_bank_if: CPU-side access bus of the MMIO register bank.
//   addr     - lane A byte address
//   wdata    - [7:0] lane A, [15:8] lane B write data
//   wr, rd   - write / read strobes
//   wide     - lane B active at addr+1
//   rdata    - registered read data, zero when idle (bus-ORable)
//   rd_valid - high the cycle after a read strobe
// Modports: master (CPU side), slave (register bank).
interface mmio_reg_bank_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              wr;
    logic              rd;
    logic              wide;
    logic [15:0]       rdata;
    logic              rd_valid;

    modport master (
        output addr, wdata, wr, rd, wide,
        input  rdata, rd_valid
    );

    modport slave (
        input  addr, wdata, wr, rd, wide,
        output rdata, rd_valid
    );
endinterface

// File: rtl/mmio_reg_bank_byte_reg.sv
// mmio_byte_reg: storage for one byte register of the MMIO bank.
//   MODE = MMIO_RW     : loads wdata_i when we_i, resets to RESET_VALUE.
//   MODE = MMIO_RO     : follows ro_in_i through SYNC_STAGES synchroniser flops
//                        plus one value flop.
//   MODE = MMIO_STICKY : accumulates rising edges of the synchronised input;
//                        rd_clr_i clears the captured bits, but an edge landing
//                        on the same cycle is kept.
// Ports: clk, rst_n (async, active low), we_i, wdata_i, rd_clr_i, ro_in_i, q_o.
module mmio_byte_reg
    import mmio_pkg::*;
#(
    parameter mmio_mode_e MODE        = MMIO_RW,
    parameter mmio_byte_t RESET_VALUE = '0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  mmio_byte_t wdata_i,
    input  logic       rd_clr_i,
    input  mmio_byte_t ro_in_i,
    output mmio_byte_t q_o
);

    mmio_byte_t q_q;

    generate
        if (MODE == MMIO_RW) begin : g_rw
            logic unused_ro;
            assign unused_ro = ^{rd_clr_i, ro_in_i};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q <= RESET_VALUE;
                end else if (we_i) begin
                    q_q <= wdata_i;
                end
            end
        end else begin : g_ro
            logic unused_wr;
            mmio_byte_t sync_w;

            assign unused_wr = ^{we_i, wdata_i};

            if (SYNC_STAGES == 0) begin : g_nosync
                assign sync_w = ro_in_i;
            end else begin : g_sync
                mmio_byte_t [SYNC_STAGES-1:0] sync_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_q <= '0;
                    end else begin
                        sync_q[0] <= ro_in_i;
                        for (int k = 1; k < SYNC_STAGES; k++) begin
                            sync_q[k] <= sync_q[k-1];
                        end
                    end
                end

                assign sync_w = sync_q[SYNC_STAGES-1];
            end

            if (MODE == MMIO_STICKY) begin : g_sticky
                mmio_byte_t sync_d_q;
                mmio_byte_t clr;
                mmio_byte_t q_d;

                assign clr = {8{rd_clr_i}};
                // Clear first, then OR in new edges, so a coincident edge survives.
                assign q_d = (q_q & ~clr) | (sync_w & ~sync_d_q);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_d_q <= '0;
                        q_q      <= '0;
                    end else begin
                        sync_d_q <= sync_w;
                        q_q      <= q_d;
                    end
                end
            end else begin : g_plain
                logic unused_clr;
                assign unused_clr = rd_clr_i;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_q <= '0;
                    end else begin
                        q_q <= sync_w;
                    end
                end
            end
        end
    endgenerate

    assign q_o = q_q;

endmodule

// File: rtl/mmio_reg_bank.sv
// mmio_reg_bank: NUM_REGS memory-mapped byte registers at BASE_ADDR with two
// byte lanes per access (lane A at addr, lane B at addr+1 when wide).
// Ports:
//   clk, reset     - system clock, asynchronous active-low reset
//   bus            - mmio_reg_bank_if.slave access bus
//   ro_in_i        - live inputs for read-only registers, byte i -> register i
//   reg_out_o      - current value of every register
//   wr_pulse_o     - one-cycle strobe after register i is written
//   err_clr_i/err_o- sticky access-error flag and its clear (only with MMIO_ERR_EN)
// Build option: define MMIO_ERR_EN to add the access-error flag.
module mmio_reg_bank
    import mmio_pkg::*;
#(
    parameter int                    ADDR_W      = 15,
    parameter logic [ADDR_W-1:0]     BASE_ADDR   = 15'h7F00,
    parameter int                    NUM_REGS    = 32,
    parameter logic [NUM_REGS-1:0]   RW_MASK     = 32'h0000_FFFF,
    parameter logic [NUM_REGS-1:0]   STICKY_MASK = '0,
    parameter logic [NUM_REGS*8-1:0] RESET_VALS  = '0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_reg_bank_if.slave        bus,
    input  logic [NUM_REGS*8-1:0] ro_in_i,
    output logic [NUM_REGS*8-1:0] reg_out_o,
    output logic [NUM_REGS-1:0]   wr_pulse_o
`ifdef MMIO_ERR_EN
    ,
    input  logic                  err_clr_i,
    output logic                  err_o
`endif
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [ADDR_W-1:0]   addr_b;
    logic [ADDR_W:0]     off_a;
    logic [ADDR_W:0]     off_b;
    logic                hit_a;
    logic                hit_b;
    logic [NUM_REGS-1:0] sel_a_v;
    logic [NUM_REGS-1:0] sel_b_v;
    logic [NUM_REGS-1:0] we_v;
    logic [NUM_REGS-1:0] rd_clr_v;
    mmio_byte_t          q [NUM_REGS];

    logic [15:0]         rdata_d;
    logic [15:0]         rdata_q;
    logic                rd_valid_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    // Offsets are computed one bit wider so an address below BASE_ADDR shows
    // up as a negative (top bit set) offset rather than wrapping into range.
    assign addr_b = bus.addr + ADDR_W'(1);
    assign off_a  = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    assign off_b  = {1'b0, addr_b}   - {1'b0, BASE_ADDR};
    assign hit_a  = !off_a[ADDR_W] && (off_a < NUM_REGS_W);
    // Lane B wrapping past the top of the address space is always a miss.
    assign hit_b  = bus.wide && (bus.addr != '1) &&
                    !off_b[ADDR_W] && (off_b < NUM_REGS_W);

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            localparam mmio_mode_e MODE =
                mmio_mode(8'(i), MMIO_WINDOW'(RW_MASK), MMIO_WINDOW'(STICKY_MASK));

            mmio_byte_t wbyte;

            assign sel_a_v[i]  = hit_a && (off_a == (ADDR_W+1)'(i));
            assign sel_b_v[i]  = hit_b && (off_b == (ADDR_W+1)'(i));
            assign we_v[i]     = bus.wr && (sel_a_v[i] || sel_b_v[i]) && (MODE == MMIO_RW);
            assign rd_clr_v[i] = bus.rd && (sel_a_v[i] || sel_b_v[i]);
            // Lanes never target the same register, so lane select is exclusive.
            assign wbyte       = sel_a_v[i] ? bus.wdata[7:0] : bus.wdata[15:8];

            mmio_byte_reg #(
                .MODE        (MODE),
                .RESET_VALUE (RESET_VALS[i*8 +: 8]),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_byte_reg (
                .clk      (clk),
                .rst_n    (reset),
                .we_i     (we_v[i]),
                .wdata_i  (wbyte),
                .rd_clr_i (rd_clr_v[i]),
                .ro_in_i  (ro_in_i[i*8 +: 8]),
                .q_o      (q[i])
            );

            assign reg_out_o[i*8 +: 8] = q[i];
        end
    endgenerate

    // Read data is sampled from the pre-edge register values, so a read and a
    // write in the same cycle return the old contents.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_a_v[i]) begin
                rdata_d[7:0] = rdata_d[7:0] | q[i];
            end
            if (sel_b_v[i]) begin
                rdata_d[15:8] = rdata_d[15:8] | q[i];
            end
        end
        if (!bus.rd) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            rdata_q    <= rdata_d;
            rd_valid_q <= bus.rd;
            wr_pulse_q <= we_v;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign wr_pulse_o   = wr_pulse_q;

`ifdef MMIO_ERR_EN
    logic in_win;
    logic ro_hit;
    logic err_set;
    logic err_q;

    assign in_win  = !off_a[ADDR_W] && (off_a < (ADDR_W+1)'(MMIO_WINDOW));
    assign ro_hit  = |((sel_a_v | sel_b_v) & ~RW_MASK);
    assign err_set = in_win &&
                     ((bus.wr && ro_hit) ||
                      ((bus.rd || bus.wr) && (!hit_a || (bus.wide && !hit_b))));

    // Set has priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_mmio_reg_bank.sv
// Self-checking bench for mmio_reg_bank: directed cases followed by random
// traffic, all compared against a behavioural model of the register bank.
module tb_mmio_reg_bank;

    localparam int            ADDR_W = 15;
    localparam int            BASE   = 32'h7F00;
    localparam int            NR     = 32;
    localparam int            S      = 2;
    localparam logic [31:0]   RWM    = 32'h0000_FFFF;
    localparam logic [31:0]   STM    = 32'h0F00_0000;
    localparam logic [255:0]  RV     = 256'h0700_5A00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_reg_bank_if #(.ADDR_W(ADDR_W)) bus ();

    logic [255:0] ro_in;
    logic [255:0] reg_out;
    logic [31:0]  wr_pulse;
`ifdef MMIO_ERR_EN
    logic err;
`endif

    mmio_reg_bank #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (15'h7F00),
        .NUM_REGS    (NR),
        .RW_MASK     (RWM),
        .STICKY_MASK (STM),
        .RESET_VALS  (RV),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ro_in_i    (ro_in),
        .reg_out_o  (reg_out),
        .wr_pulse_o (wr_pulse)
`ifdef MMIO_ERR_EN
        ,
        .err_clr_i  (1'b0),
        .err_o      (err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural model
    logic [31:0]  rw_v  = RWM;
    logic [31:0]  st_v  = STM;
    logic [255:0] rv_v  = RV;
    logic [7:0]   rw_m [NR];
    logic [7:0]   st_m [NR];
    logic [255:0] hist [$];       // ro_in as sampled at each edge, newest last
    logic [15:0]  exp_rdata;
    logic         exp_valid;
    logic [31:0]  exp_pulse;

    function automatic logic [255:0] samp(input int k);
        if (hist.size() > k) return hist[hist.size()-1-k];
        return '0;
    endfunction

    function automatic logic [7:0] mval(input int i);
        logic [255:0] s;
        s = samp(S);
        if (rw_v[i]) return rw_m[i];
        if (st_v[i]) return st_m[i];
        return s[i*8 +: 8];
    endfunction

    function automatic logic [255:0] exp_regout();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*8 +: 8] = mval(i);
        return r;
    endfunction

    function automatic void decode(input int a, input bit w,
                                   output int ia, output int ib,
                                   output bit ha, output bit hb);
        int b;
        ia = a - BASE;
        ha = (ia >= 0) && (ia < NR);
        b  = (a + 1) % (1 << ADDR_W);
        ib = b - BASE;
        hb = w && (a != (1 << ADDR_W) - 1) && (ib >= 0) && (ib < NR);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            rw_m[i] = rv_v[i*8 +: 8];
            st_m[i] = 8'h00;
        end
        hist.delete();
        exp_rdata = '0;
        exp_valid = 1'b0;
        exp_pulse = '0;
    endtask

    task automatic model_edge();
        int ia, ib;
        bit ha, hb;
        logic [255:0] a, p;
        decode(int'(bus.addr), bus.wide, ia, ib, ha, hb);
        exp_rdata = '0;
        if (bus.rd) begin
            if (ha) exp_rdata[7:0]  = mval(ia);
            if (hb) exp_rdata[15:8] = mval(ib);
        end
        exp_valid = bus.rd;
        exp_pulse = '0;
        hist.push_back(ro_in);
        if (hist.size() > 8) void'(hist.pop_front());
        a = samp(S);
        p = samp(S + 1);
        for (int i = 0; i < NR; i++) begin
            if (st_v[i] && !rw_v[i]) begin
                if (bus.rd && ((ha && ia == i) || (hb && ib == i))) st_m[i] = 8'h00;
                st_m[i] = st_m[i] | (a[i*8 +: 8] & ~p[i*8 +: 8]);
            end
        end
        if (bus.wr) begin
            if (ha && rw_v[ia]) begin
                rw_m[ia] = bus.wdata[7:0];
                exp_pulse[ia] = 1'b1;
            end
            if (hb && rw_v[ib]) begin
                rw_m[ib] = bus.wdata[15:8];
                exp_pulse[ib] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_rdata"},    bus.rdata,    exp_rdata);
        chk({pfx, "_rd_valid"}, bus.rd_valid, exp_valid);
        chk({pfx, "_wr_pulse"}, wr_pulse,     exp_pulse);
        chk({pfx, "_reg_out"},  reg_out,      exp_regout());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic drive(input bit r, input bit w, input bit wd, input int off,
                         input logic [15:0] data);
        bus.rd    = r;
        bus.wr    = w;
        bus.wide  = wd;
        bus.addr  = ADDR_W'(BASE + off);
        bus.wdata = data;
    endtask

    task automatic idle();
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    // Called just after a rising edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        #3 reset = 1'b1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom() & $urandom() & $urandom();
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ro_in = '0;
        drive(0, 0, 0, 0, 16'h0000);
        #1 reset = 1'b0;
        model_reset();
        #2;
        chk("reset_reg3", reg_out[31:24], 8'h07);
        chk("reset_rdata", bus.rdata, 16'h0000);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_wr_pulse", wr_pulse, 32'h0);
        check_all("reset");
        #4 reset = 1'b1;

        // Wide write to RW registers 4/5; RO inputs for 20 and 31 applied now.
        ro_in[20*8 +: 8] = 8'h5C;
        ro_in[31*8 +: 8] = 8'h3C;
        drive(0, 1, 1, 4, 16'hBEEF);
        tick();
        chk("beef_reg4", reg_out[39:32], 8'hEF);
        chk("beef_reg5", reg_out[47:40], 8'hBE);
        chk("beef_pulse", wr_pulse, 32'h0000_0030);

        drive(0, 1, 0, 20, 16'h00AA);
        tick();
        chk("ro_write_no_pulse", wr_pulse, 32'h0);
        idle();
        tick();

        drive(1, 0, 1, 4, 16'h0000);
        tick();
        chk("beef_readback", bus.rdata, 16'hBEEF);
        chk("beef_rd_valid", bus.rd_valid, 1'b1);

        drive(1, 0, 0, 20, 16'h0000);
        tick();
        chk("ro20_read", bus.rdata, 16'h005C);

        drive(1, 0, 1, NR - 1, 16'h0000);
        tick();
        chk("top_wide_read", bus.rdata, 16'h003C);

        drive(0, 1, 0, 0, 16'h0011);
        tick();
        drive(1, 1, 0, 0, 16'h0022);
        tick();
        chk("rdwr_old", bus.rdata, 16'h0011);
        drive(1, 0, 0, 0, 16'h0000);
        tick();
        chk("rdwr_new", bus.rdata, 16'h0022);

        // Sticky register 24: one rising edge on bit 2.
        idle();
        ro_in[24*8 + 2] = 1'b1;
        repeat (3) tick();
        ro_in[24*8 + 2] = 1'b0;
        repeat (4) tick();
        drive(1, 0, 0, 24, 16'h0000);
        tick();
        chk("sticky_first", bus.rdata, 16'h0004);

        // New edge captured on the same edge as the clearing read.
        idle();
        ro_in[24*8 + 2] = 1'b1;
        tick();
        tick();
        drive(1, 0, 0, 24, 16'h0000);
        tick();
        chk("sticky_cleared", bus.rdata, 16'h0000);
        idle();
        ro_in[24*8 + 2] = 1'b0;
        tick();
        drive(1, 0, 0, 24, 16'h0000);
        tick();
        chk("sticky_retained", bus.rdata, 16'h0004);

        // Reset while a read and a write are outstanding.
        drive(1, 1, 1, 4, 16'h1234);
        tick();
        do_reset();
        chk("midrst_reg4", reg_out[39:32], 8'h00);
        chk("midrst_rd_valid", bus.rd_valid, 1'b0);
        idle();
        tick();

        // Random traffic around and inside the bank window.
        for (int n = 0; n < 600; n++) begin
            int off;
            if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 255);
            else off = int'($urandom_range(0, 40)) - 4;
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  off, 16'($urandom()));
            if ($urandom_range(0, 3) == 0) ro_in = ro_in ^ rnd256();
            tick();
            if (n == 300) do_reset();
        end

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
